// File: rtl/fetch_btb.sv
// Instruction-fetch stage: PC register, instruction-memory address, and a
// direct-mapped BTB with 2-bit saturating counters for next-PC prediction.
module fetch_btb #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] Instruction,
    output logic [31:0] nextPC,
    output logic        hit
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic [31:0]            pc;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [29:0]            target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [31:0]      pc_plus4;
    logic [31:0]      pred_pc;
    logic [31:0]      pc_next;

    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_match;

    // Low address bits are architecturally ignored on these inputs.
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Lookup is purely combinational on the pre-edge PC and BTB state.
    assign look_idx = pc[IDX+1:2];
    assign look_tag = pc[31:IDX+2];
    assign pc_plus4 = pc + 32'd4;
    assign hit      = valid_q[look_idx] && (tag_q[look_idx] == look_tag) && ctr_q[look_idx][1];
    assign pred_pc  = hit ? {target_q[look_idx], 2'b00} : pc_plus4;

    assign imem_addr   = pc;
    assign nextPC      = pc_plus4;
    assign Instruction = imem_data;

    always_comb begin
        pc_next = pred_pc;
        if (redirect) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign upd_idx   = upd_pc[IDX+1:2];
    assign upd_tag   = upd_pc[31:IDX+2];
    assign upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Training ignores stall/redirect; a not-taken miss leaves the entry alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_match) begin
                if (upd_taken) begin
                    ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    target_q[upd_idx] <= upd_target[31:2];
                end else begin
                    ctr_q[upd_idx] <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target[31:2];
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_btb.sv
// Bench for fetch_btb: directed scenarios plus randomized traffic checked
// against a table-based model of the BTB and PC update rules.
module tb_fetch_btb;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] imem_addr, imem_data, Instruction, nextPC;
    logic        hit;

    logic        w_zero1;
    logic [31:0] w_zero32;
    logic [31:0] w_imem_addr, w_imem_data, w_instruction, w_nextpc;
    logic        w_hit;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_5A5A;
    endfunction

    assign imem_data   = imem_fn(imem_addr);
    assign w_imem_data = imem_fn(w_imem_addr);

    fetch_btb #(.BTB_ENTRIES(N), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .imem_addr(imem_addr),
        .imem_data(imem_data), .Instruction(Instruction), .nextPC(nextPC), .hit(hit)
    );

    fetch_btb #(.BTB_ENTRIES(N), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(w_zero1), .redirect(w_zero1),
        .redirect_pc(w_zero32), .upd_valid(w_zero1), .upd_pc(w_zero32),
        .upd_target(w_zero32), .upd_taken(w_zero1), .imem_addr(w_imem_addr),
        .imem_data(w_imem_data), .Instruction(w_instruction), .nextPC(w_nextpc), .hit(w_hit)
    );

    function automatic int m_index(input logic [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a / (4 * N);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int i;
        i = m_index(a);
        return m_valid[i] && (m_tag[i] == m_tagof(a)) && (m_ctr[i] >= 2);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0;
    endtask

    // Advance one clock; model next state is computed from pre-edge inputs.
    task automatic tick();
        logic [31:0] npc;
        int          i;
        if (redirect)   npc = redirect_pc & ~32'h3;
        else if (stall) npc = m_pc;
        else if (m_hit(m_pc)) npc = m_tgt[m_index(m_pc)];
        else            npc = m_pc + 32'd4;
        @(posedge clk);
        m_pc = npc;
        if (upd_valid) begin
            i = m_index(upd_pc);
            if (m_valid[i] && m_tag[i] == m_tagof(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target & ~32'h3;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = m_tagof(upd_pc);
                m_tgt[i]   = upd_target & ~32'h3;
                m_ctr[i]   = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] seq [4];
        seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h8; seq[3] = 32'hC;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (imem_addr !== 32'h0 || nextPC !== 32'h4 || hit !== 1'b0 || Instruction !== imem_fn(32'h0)) begin
            failures++;
            $display("FAIL reset_outputs: addr=%h next=%h hit=%b instr=%h, expected addr=0 next=4 hit=0 instr=%h",
                     imem_addr, nextPC, hit, Instruction, imem_fn(32'h0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_addr !== seq[k] || nextPC !== seq[k] + 32'd4 || hit !== 1'b0) begin
                failures++;
                $display("FAIL seq_fetch%0d: addr=%h next=%h hit=%b, expected addr=%h next=%h hit=0",
                         k, imem_addr, nextPC, hit, seq[k], seq[k] + 32'd4);
            end
            if (k < 2) tick();
        end
        // Asynchronous reset at PC=0x8, mid low phase
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: addr=%h expected 00000000", imem_addr);
        end
        // Pending redirect/update during reset must be discarded
        redirect = 1'b1; redirect_pc = 32'h500;
        upd_valid = 1'b1; upd_pc = 32'h0; upd_target = 32'h300; upd_taken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (imem_addr !== seq[k] || nextPC !== seq[k] + 32'd4 || hit !== 1'b0 || imem_addr !== m_pc) begin
                failures++;
                $display("FAIL post_reset_seq%0d: addr=%h next=%h hit=%b, expected addr=%h hit=0",
                         k, imem_addr, nextPC, hit, seq[k]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        checks++;
        if (w_imem_addr !== 32'hFFFF_FFFC || w_nextpc !== 32'h0 || w_hit !== 1'b0) begin
            failures++;
            $display("FAIL wrap_reset: addr=%h next=%h hit=%b, expected FFFFFFFC 00000000 0",
                     w_imem_addr, w_nextpc, w_hit);
        end
        tick();
        checks++;
        if (w_imem_addr !== 32'h0 || w_instruction !== imem_fn(32'h0)) begin
            failures++;
            $display("FAIL wrap_second_fetch: addr=%h instr=%h, expected 00000000 %h",
                     w_imem_addr, w_instruction, imem_fn(32'h0));
        end
    endtask

    task automatic test_stall();
        redirect = 1'b1; redirect_pc = 32'h10;
        tick();
        idle_inputs();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stall = 1'b0;
            checks++;
            if (imem_addr !== 32'h10 || Instruction !== imem_fn(32'h10) || imem_addr !== m_pc) begin
                failures++;
                $display("FAIL stall_hold%0d: addr=%h instr=%h, expected addr=00000010 instr=%h",
                         k, imem_addr, Instruction, imem_fn(32'h10));
            end
            tick();
        end
        checks++;
        if (imem_addr !== 32'h14 || Instruction !== imem_fn(32'h14)) begin
            failures++;
            $display("FAIL stall_release: addr=%h expected 00000014", imem_addr);
        end
    endtask

    task automatic test_alloc();
        upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h100; upd_taken = 1'b1;
        tick();
        idle_inputs();
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        idle_inputs();
        checks++;
        if (imem_addr !== 32'h20 || hit !== 1'b1 || nextPC !== 32'h24) begin
            failures++;
            $display("FAIL alloc_hit: addr=%h hit=%b next=%h, expected 00000020 1 00000024",
                     imem_addr, hit, nextPC);
        end
        tick();
        checks++;
        if (imem_addr !== 32'h100 || imem_addr !== m_pc) begin
            failures++;
            $display("FAIL alloc_target: addr=%h expected 00000100", imem_addr);
        end
    endtask

    task automatic test_hysteresis();
        logic       exp_hit [5];
        logic       taken_seq [4];
        exp_hit[0] = 1'b1; exp_hit[1] = 1'b0; exp_hit[2] = 1'b0; exp_hit[3] = 1'b0; exp_hit[4] = 1'b1;
        taken_seq[0] = 1'b0; taken_seq[1] = 1'b0; taken_seq[2] = 1'b1; taken_seq[3] = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        idle_inputs();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            // lookup sees pre-edge state, so the first update is not yet visible
            checks++;
            if (hit !== exp_hit[k] || hit !== m_hit(m_pc)) begin
                failures++;
                $display("FAIL hysteresis%0d: hit=%b expected %b", k, hit, exp_hit[k]);
            end
            if (k < 4) begin
                upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h100; upd_taken = taken_seq[k];
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic test_alias_priority();
        redirect = 1'b1; redirect_pc = 32'h60;
        tick();
        idle_inputs();
        checks++;
        if (imem_addr !== 32'h60 || hit !== 1'b0 || nextPC !== 32'h64) begin
            failures++;
            $display("FAIL alias: addr=%h hit=%b next=%h, expected 00000060 0 00000064", imem_addr, hit, nextPC);
        end
        tick();
        checks++;
        if (imem_addr !== 32'h64) begin
            failures++;
            $display("FAIL alias_next: addr=%h expected 00000064", imem_addr);
        end
        redirect = 1'b1; redirect_pc = 32'h203; stall = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL redirect_over_stall: addr=%h expected 00000200", imem_addr);
        end
        redirect_pc = 32'h347;
        tick();
        checks++;
        if (imem_addr !== 32'h344) begin
            failures++;
            $display("FAIL redirect_held: addr=%h expected 00000344", imem_addr);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 6) == 0);
            redirect_pc = $urandom_range(0, 511);
            upd_valid   = ($urandom_range(0, 9) < 4);
            upd_pc      = $urandom & 32'h0000_03FF;
            upd_target  = $urandom_range(0, 1023);
            upd_taken   = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (imem_addr !== m_pc || nextPC !== m_pc + 32'd4 || hit !== m_hit(m_pc) ||
                Instruction !== imem_fn(m_pc)) begin
                failures++;
                $display("FAIL random%0d: addr=%h next=%h hit=%b instr=%h, expected addr=%h next=%h hit=%b instr=%h",
                         k, imem_addr, nextPC, hit, Instruction, m_pc, m_pc + 32'd4, m_hit(m_pc), imem_fn(m_pc));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        w_zero1 = 1'b0;
        w_zero32 = 32'h0;
        test_reset();
        // fresh reset so the wrap instance starts from its reset PC
        rst_n = 1'b0;
        model_reset();
        m_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        rst_n = 1'b1;
        test_wrap();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_stall();
        test_alloc();
        test_hysteresis();
        test_alias_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_btb.md
# fetch_btb

Instruction-fetch stage feeding the IF/ID pipeline register. Holds the program counter, presents the fetch address to instruction memory and forwards the returned word. Predicts the next fetch address with a direct-mapped branch target buffer (BTB) using 2-bit saturating counters. Produces `nextPC`, `Instruction` and `hit` exactly as IF/ID consumes them, and accepts redirects and BTB training from the execute stage.

## Interface
- `BTB_ENTRIES`, 16: number of BTB entries; power of two, minimum 2. `IDX = log2(BTB_ENTRIES)`.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; word-aligned.

- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard-unit hold; the PC does not advance.
- `redirect`  in  1  EX mispredict or jump correction.
- `redirect_pc`  in  32  corrected fetch address; bits [1:0] are ignored and treated as 00.
- `upd_valid`  in  1  BTB training strobe for one resolved branch.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_target`  in  32  resolved target; bits [1:0] are ignored.
- `upd_taken`  in  1  resolved direction.
- `imem_addr`  out  32  fetch address; equals the PC register.
- `imem_data`  in  32  instruction word; combinational read of `imem_addr` in the same cycle.
- `Instruction`  out  32  equals `imem_data`, passed through to IF/ID.
- `nextPC`  out  32  PC+4, modulo 2^32.
- `hit`  out  1  BTB predicts taken for the current PC.

## Operation
- BTB entry fields: `valid`, `tag` = PC[31:IDX+2], `target`[31:2], `ctr`[1:0].
- Lookup index: PC[IDX+1:2].
- `hit` is asserted when `valid`, the tag matches and `ctr[1]` is 1. All three terms are combinational from the PC and current BTB state.
- Predicted next PC: `target` when `hit` is 1, otherwise PC+4.
- PC update priority, applied at each rising edge:
  - `redirect` loads `redirect_pc`. This wins over `stall`.
  - otherwise `stall` holds the PC.
  - otherwise the PC loads the predicted next PC.
- Training with `upd_valid` = 1. The index is `upd_pc`[IDX+1:2].
  - On a tag match with `valid`: `ctr` increments, saturating at 3, when `upd_taken` is 1, and decrements, saturating at 0, otherwise. `target` is overwritten only when `upd_taken` is 1.
  - On a miss with `upd_taken` = 1: allocate or replace the entry with `valid`=1, the new tag, `target`=`upd_target`, `ctr`=2'b10 (weakly taken).
  - On a miss with `upd_taken` = 0: no change.
- Training is independent of `stall` and `redirect`. It occurs in the same edge as any PC update.
- Alias rule: a tag mismatch forces `hit`=0 regardless of `ctr`.

## Timing
- Reset, asynchronous and effective immediately:
  - PC = `RESET_PC`, all `valid`=0, all `ctr`=2'b01.
  - Outputs: `imem_addr`=`RESET_PC`, `nextPC`=`RESET_PC`+4, `hit`=0, `Instruction`=`imem_data`.
- Reset asserted mid-operation discards any pending redirect and any pending update.
- After reset release, the first fetch occurs in the first cycle. The PC advances on the first rising edge with `rst_n`=1.
- `hit`, `nextPC` and `Instruction` are valid in the same cycle as `imem_addr`. IF/ID registers them.
- Branch prediction has zero bubbles: the predicted target is fetched in the cycle after `hit`.
- A redirect costs one edge: `imem_addr` = `redirect_pc` in the cycle after `redirect` is sampled.
- Training that writes to the index currently being looked up is visible only from the next cycle. The lookup always uses the pre-edge state.
- Wrap-around: PC = 32'hFFFF_FFFC gives `nextPC`=0, and the PC advances to 0 when not predicted and not stalled.
- `stall` and `redirect` may be held for any number of cycles. While `redirect` stays high, the PC reloads `redirect_pc` every edge.

## Test plan
- Reset and sequential fetch: pulse `rst_n` low, then release it with no stall or redirect. Required: `imem_addr` = 0, 4, 8, 12 on successive cycles, `nextPC` = `imem_addr`+4, `hit`=0 throughout. Assert `rst_n` low asynchronously at PC=0x8. Required: `imem_addr`=0 before the next edge.
- Stall: with PC=0x10, hold `stall` high for 3 cycles. Required: `imem_addr` stays 0x10 for 4 cycles, then becomes 0x14. `Instruction` tracks `imem_data` throughout.
- Allocation and prediction:
  - Apply `upd_valid`, `upd_pc`=0x20, `upd_target`=0x100, `upd_taken`=1.
  - Later fetch PC 0x20. Required: `hit`=1, `nextPC`=0x24, next `imem_addr`=0x100.
- Counter hysteresis on the 0x20 entry (`ctr`=2'b10):
  - Apply two not-taken updates. Required: `ctr` goes to 01 then 00, and `hit`=0 at 0x20.
  - Apply two taken updates. Required: `ctr` reaches 10 and `hit`=1.
- Aliasing and priority:
  - With the 0x20 entry allocated, fetch 0x60, which shares index 8 when `BTB_ENTRIES`=16. Required: `hit`=0.
  - Assert `redirect`, `redirect_pc`=0x203 and `stall` together. Required: next `imem_addr`=0x200.
- Wrap: set `RESET_PC`=32'hFFFF_FFFC. Required: `nextPC`=0 and the second fetch address is 0.
